blend_frame_writer: RTL and testbench

Sink end of the two-image blend path: accepts pairs of scaled pixel bytes (the upper bytes of the 0.5-weighted approximate-multiplier products), sums them into one output pixel and writes the result into the output frame memory at consecutive addresses. It replaces the bench-side accumulation/write loop with synthesizable RTL and includes a small elastic FIFO that absorbs memory back-pressure. One invocation writes exactly one frame, then pulses `frame_done`.

---
 rtl/blend_frame_writer.sv | 144 ++++++++++++++
 tb/tb_blend_frame_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blend_frame_writer.sv
// rtl/blend_frame_writer.sv - sums scaled pixel pairs and writes one frame to memory through an elastic FIFO
// Optional feature macro: BLEND_SAT_EN (saturate the pixel sum at 8'hFF instead of wrapping)
module blend_frame_writer #(
    parameter int FRAME_PIXELS = 270000,
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_p1,
    input  logic [7:0]        in_p2,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_COUNT = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] acc_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              arm;
    logic              last_ack;
    logic [7:0]        sum;

`ifdef BLEND_SAT_EN
    logic [8:0] sum_full;
    assign sum_full = {1'b0, in_p1} + {1'b0, in_p2};
    assign sum      = sum_full[8] ? 8'hFF : sum_full[7:0];
`else
    assign sum = in_p1 + in_p2;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign in_ready   = (state == RUN) && !fifo_full && (acc_cnt != LAST_COUNT);
    assign push       = in_valid && in_ready;
    assign mem_wr_en  = !fifo_empty && ((state == RUN) || (state == FLUSH));
    assign pop        = mem_wr_en && mem_ack;
    assign last_ack   = pop && (wr_cnt == LAST_INDEX);
    assign arm        = (state == IDLE) && start;

    assign mem_addr   = wr_cnt;
    assign mem_wdata  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];
    assign pix_count  = wr_cnt;
    assign busy       = (state == RUN) || (state == FLUSH);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final acknowledge can land while still in RUN, so both busy states watch for it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_ack) begin
                    state_next = DONE;
                end else if (acc_cnt == LAST_COUNT) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (last_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (arm) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= sum;
        end
    end

endmodule

// File: tb/tb_blend_frame_writer.sv
// tb/tb_blend_frame_writer.sv - table-driven scoreboard bench for blend_frame_writer
module tb_blend_frame_writer;

    localparam int FP = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          mem_ack = 1'b0;
    logic [7:0]    in_p1 = 8'h00;
    logic [7:0]    in_p2 = 8'h00;
    logic          in_ready;
    logic          mem_wr_en;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pix_count;
    logic [7:0]    mem_wdata;

    blend_frame_writer #(
        .FRAME_PIXELS(FP),
        .ADDR_W      (AW),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p1     (in_p1),
        .in_p2     (in_p2),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .frame_done(frame_done),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] sb [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_addr = 0;
    int nwr = 0;
    int nacc = 0;
    int done_cnt = 0;
    int last_ack_cyc = 0;
    int done_cyc = 0;
    int idx = FP;
    int base = 0;
    bit extra_valid = 1'b0;
    bit held = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [7:0]    held_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write-side monitor: pops the scoreboard and checks address order and hold stability
    always @(negedge clk) begin
        if (mem_wr_en && held) begin
            chk("hold_addr", int'(mem_addr), int'(held_addr));
            chk("hold_data", int'(mem_wdata), int'(held_data));
        end
        held      = mem_wr_en && !mem_ack;
        held_addr = mem_addr;
        held_data = mem_wdata;
        if (mem_wr_en && mem_ack) begin
            if (sb.size() == 0) begin
                chk("write_without_accept", 1, 0);
            end else begin
                chk("wdata", int'(mem_wdata), int'(sb.pop_front()));
            end
            chk("waddr", int'(mem_addr), exp_addr);
            if (exp_addr == FP - 1) last_ack_cyc = cyc;
            exp_addr++;
            nwr++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        in_valid = (idx < FP) || extra_valid;
        if (idx < FP) begin
            in_p1 = tbl[base + idx].p1;
            in_p2 = tbl[base + idx].p2;
        end
        @(negedge clk);
        if (idx >= FP && extra_valid) begin
            chk("ready_low_after_frame", int'(in_ready), 0);
        end else if (in_valid && in_ready) begin
            sb.push_back(tbl[base + idx].exp);
            idx++;
            nacc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        base     = b;
        idx      = 0;
        nacc     = 0;
        nwr      = 0;
        exp_addr = 0;
        done_cnt = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int max_cyc);
        int t = 0;
        while (done_cnt == 0 && t < max_cyc) begin
            tick();
            t++;
        end
        if (done_cnt == 0) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, "_writes"}, nwr, FP);
        chk({tag, "_pix_count"}, int'(pix_count), FP);
        chk({tag, "_done_delay"}, done_cyc - last_ack_cyc, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_mem_wr_en"}, int'(mem_wr_en), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_pix_count"}, int'(pix_count), 0);
    endtask

    initial begin
        tbl[0]  = '{8'h10, 8'h20, 8'h30};
        tbl[1]  = '{8'h11, 8'h21, 8'h32};
        tbl[2]  = '{8'h12, 8'h22, 8'h34};
        tbl[3]  = '{8'h13, 8'h23, 8'h36};
        tbl[4]  = '{8'h14, 8'h24, 8'h38};
        tbl[5]  = '{8'h15, 8'h25, 8'h3A};
        tbl[6]  = '{8'h16, 8'h26, 8'h3C};
        tbl[7]  = '{8'h17, 8'h27, 8'h3E};
`ifdef BLEND_SAT_EN
        tbl[8]  = '{8'hC0, 8'h50, 8'hFF};
        tbl[10] = '{8'hFF, 8'h01, 8'hFF};
        tbl[15] = '{8'hFF, 8'hFF, 8'hFF};
`else
        tbl[8]  = '{8'hC0, 8'h50, 8'h10};
        tbl[10] = '{8'hFF, 8'h01, 8'h00};
        tbl[15] = '{8'hFF, 8'hFF, 8'hFE};
`endif
        tbl[9]  = '{8'h80, 8'h7F, 8'hFF};
        tbl[11] = '{8'h00, 8'h00, 8'h00};
        tbl[12] = '{8'h01, 8'h02, 8'h03};
        tbl[13] = '{8'h7F, 8'h7F, 8'hFE};
        tbl[14] = '{8'hAA, 8'h55, 8'hFF};

        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight frame with trailing in_valid and a stray start mid-frame
        mem_ack     = 1'b1;
        extra_valid = 1'b1;
        do_start(0);
        chk("start_busy", int'(busy), 1);
        chk("start_in_ready", int'(in_ready), 1);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(40);
        frame_checks("straight");
        extra_valid = 1'b0;

        // Back-to-back frame with overflow arithmetic, started the cycle after frame_done
        do_start(8);
        run_to_done(40);
        frame_checks("overflow");
        tick();
        chk("overflow_done_pulses", done_cnt, 1);

        // Back-pressure: memory stalls for ten cycles
        mem_ack = 1'b0;
        do_start(0);
        tick();
        chk("lat_wr_en", int'(mem_wr_en), 1);
        chk("lat_wdata", int'(mem_wdata), 8'h30);
        chk("lat_addr", int'(mem_addr), 0);
        repeat (9) tick();
        chk("bp_accepts", nacc, 4);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_writes", nwr, 0);
        mem_ack = 1'b1;
        run_to_done(40);
        frame_checks("backpressure");

        // Reset after three writes, then a full frame from address 0
        do_start(8);
        for (int t = 0; t < 40 && nwr < 3; t++) tick();
        chk("pre_reset_writes", nwr, 3);
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        sb.delete();
        held     = 1'b0;
        idx      = FP;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(0);
        run_to_done(40);
        frame_checks("after_reset");
        tick();
        chk("after_reset_done_pulses", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
